// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave that moves bytes between a serial master and the PCLK domain.
// Ports: PCLK/PRESETn system clock and async active-low reset; sclk, ss, mosi, miso SPI pins;
// cpol/cpha/lsbfe mode controls captured while ss is high; tx_data/tx_load/tx_ready single-byte
// transmit buffer; rx_data/rx_valid received byte and pulse; tx_underrun sticky empty-buffer
// flag; frame_err pulse when ss rises mid-byte.
module spi_slave_if (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       frame_err
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [2:0] ss_q, sclk_q, mosi_q;
    logic [1:0] rst_q;
    logic [0:0] state;
    logic [2:0] cnt;
    logic [7:0] rx_sr, tx_sr, tx_buf;
    logic       armed, rise_p, fall_p, c_cpol, c_cpha, c_lsb, buf_full;
    logic       in_shift, ss_fall, ss_rise, lead, trail, sample, shift_e, wrap, consume, accept;
    logic [7:0] next_byte, rx_next, nb_sh, sr_sh;
    logic       nb_bit, sr_bit;
    // A falling ss only starts a frame once ss has been seen high after reset,
    // so a reset released while ss is still low cannot open a frame mid-byte.
    assign ss_fall   = armed & ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign in_shift  = state == SHIFT;
    assign lead      = c_cpol ? fall_p : rise_p;
    assign trail     = c_cpol ? rise_p : fall_p;
    assign sample    = in_shift & ~ss_rise & (c_cpha ? trail : lead);
    assign shift_e   = in_shift & ~ss_rise & (c_cpha ? lead : trail);
    assign wrap      = sample & (cnt == 3'd7);
    assign consume   = (~in_shift & ss_fall) | wrap;
    assign accept    = tx_load & (~buf_full | consume);
    assign tx_ready  = ~buf_full;
    assign next_byte = buf_full ? tx_buf : 8'hFF;
    assign nb_bit    = c_lsb ? next_byte[0] : next_byte[7];
    assign nb_sh     = c_lsb ? {1'b0, next_byte[7:1]} : {next_byte[6:0], 1'b0};
    assign sr_bit    = c_lsb ? tx_sr[0] : tx_sr[7];
    assign sr_sh     = c_lsb ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
    // mosi_q[2] lines up with the registered edge pulses one stage behind the detector.
    assign rx_next   = c_lsb ? {mosi_q[2], rx_sr[7:1]} : {rx_sr[6:0], mosi_q[2]};
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ss_q        <= 3'b111;
            sclk_q      <= 3'b000;
            mosi_q      <= 3'b000;
            rst_q       <= 2'b00;
            armed       <= 1'b0;
            rise_p      <= 1'b0;
            fall_p      <= 1'b0;
            c_cpol      <= 1'b0;
            c_cpha      <= 1'b0;
            c_lsb       <= 1'b0;
            state       <= IDLE;
            cnt         <= 3'd0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'h00;
            tx_buf      <= 8'h00;
            buf_full    <= 1'b0;
            miso        <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            ss_q        <= {ss_q[1:0], ss};
            sclk_q      <= {sclk_q[1:0], sclk};
            mosi_q      <= {mosi_q[1:0], mosi};
            rst_q       <= {rst_q[0], 1'b1};
            armed       <= armed | (rst_q[1] & ss_q[1]);
            rise_p      <= sclk_q[1] & ~sclk_q[2];
            fall_p      <= ~sclk_q[1] & sclk_q[2];
            rx_valid    <= wrap;
            frame_err   <= in_shift & ss_rise & (cnt != 3'd0);
            buf_full    <= accept | (buf_full & ~consume);
            // An empty-buffer consumption sets the flag even if a load lands in the same cycle.
            tx_underrun <= (tx_underrun & ~accept) | (consume & ~buf_full);
            if (accept) tx_buf <= tx_data;
            if (ss_q[1]) begin
                c_cpol <= cpol;
                c_cpha <= cpha;
                c_lsb  <= lsbfe;
            end
            if (!in_shift) begin
                if (ss_fall) begin
                    state <= SHIFT;
                    cnt   <= 3'd0;
                    rx_sr <= 8'h00;
                    tx_sr <= c_cpha ? next_byte : nb_sh;
                    miso  <= c_cpha ? 1'b0 : nb_bit;
                end
            end else if (ss_rise) begin
                state <= IDLE;
                cnt   <= 3'd0;
                rx_sr <= 8'h00;
                miso  <= 1'b0;
            end else begin
                if (sample) begin
                    rx_sr <= rx_next;
                    cnt   <= cnt + 3'd1;
                end
                // Reload holds the whole next byte; its first bit leaves on the next shift edge.
                if (wrap) begin
                    rx_data <= rx_next;
                    tx_sr   <= next_byte;
                end
                if (shift_e) begin
                    miso  <= sr_bit;
                    tx_sr <= sr_sh;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed and randomized SPI frames checked against a byte-level model.
module tb_spi_slave_if;
    localparam int H = 60;
    logic       PCLK = 1'b0, PRESETn = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0, tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, tx_ready, rx_valid, tx_underrun, frame_err;
    logic [7:0] rx_data;
    int         npass = 0, nfail = 0, ntot = 0;
    int         rxv_n = 0, ferr_n = 0;
    logic [7:0] rx_q[$];
    time        rxv_t = 0, samp_t = 0;
    logic       cpol_r = 1'b0, cpha_r = 1'b0, lsb_r = 1'b0;
    logic       mfull = 1'b0, munder = 1'b0;
    logic [7:0] mbuf = 8'h00, rx_last = 8'h00;
    logic [7:0] e0, e1, m0, m1, mi0, mi1;
    logic [7:0] ex[3], mo[2], mi[2];
    int         nb;
    logic       ld[2];
    logic [7:0] ldd[2];

    spi_slave_if dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_err(frame_err)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (rx_valid) begin
            rxv_n++;
            rx_q.push_back(rx_data);
            rxv_t = $time;
        end
        if (frame_err) ferr_n++;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        ntot++;
        assert (o === e) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Byte-level model of the transmit buffer: each frame start and each completed
    // byte while ss is low takes one byte (or 0xFF and flags underrun).
    function automatic logic [7:0] m_take();
        if (mfull) begin
            mfull = 1'b0;
            return mbuf;
        end
        munder = 1'b1;
        return 8'hFF;
    endfunction

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        #10;
        tx_load = 1'b0;
        if (!mfull) begin
            mbuf   = d;
            mfull  = 1'b1;
            munder = 1'b0;
        end
    endtask

    task automatic set_mode(input logic c, input logic p, input logic l);
        cpol_r = c; cpha_r = p; lsb_r = l;
        cpol = c; cpha = p; lsbfe = l;
        sclk = c;
        #(2*H);
    endtask

    task automatic xfer(input logic [7:0] d, input int n, output logic [7:0] r);
        int k;
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            k = lsb_r ? i : 7 - i;
            if (!cpha_r) begin
                mosi = d[k]; #H;
                sclk = ~cpol_r; samp_t = $time; r[k] = miso; #H;
                sclk = cpol_r;
            end else begin
                sclk = ~cpol_r; mosi = d[k]; #H;
                sclk = cpol_r; samp_t = $time; r[k] = miso; #H;
            end
        end
    endtask

    task automatic frame_begin();
        rx_q.delete();
        rxv_n = 0;
        ferr_n = 0;
        ss = 1'b0;
        #(2*H);
    endtask

    task automatic frame_end();
        #H;
        ss = 1'b1;
        #(2*H);
    endtask

    initial begin
        #10;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_underrun", 32'(tx_underrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        #10 PRESETn = 1'b1;
        #(3*H);

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        load(8'hA5);
        chk("A_tx_ready", 32'(tx_ready), 32'd0);
        frame_begin();
        e0 = m_take();
        chk("A_underrun_start", 32'(tx_underrun), 32'(munder));
        xfer(8'h3C, 8, mi0);
        e1 = m_take();
        frame_end();
        chk("A_miso", 32'(mi0), 32'(e0));
        chk("A_rx_data", 32'(rx_data), 32'h3C);
        chk("A_rx_pulses", 32'(rxv_n), 32'd1);
        chk("A_latency", 32'(rxv_t - samp_t), 32'd40);
        chk("A_idle_miso", 32'(miso), 32'd0);

        // Mode 3, LSB first
        set_mode(1'b1, 1'b1, 1'b1);
        load(8'h81);
        frame_begin();
        e0 = m_take();
        xfer(8'hAA, 8, mi0);
        e1 = m_take();
        frame_end();
        chk("B_miso", 32'(mi0), 32'(e0));
        chk("B_rx_data", 32'(rx_data), 32'hAA);
        chk("B_rx_pulses", 32'(rxv_n), 32'd1);

        // Empty buffer at frame start
        set_mode(1'b0, 1'b0, 1'b0);
        frame_begin();
        e0 = m_take();
        chk("C_underrun_start", 32'(tx_underrun), 32'(munder));
        m0 = 8'($urandom);
        xfer(m0, 8, mi0);
        e1 = m_take();
        frame_end();
        chk("C_miso", 32'(mi0), 32'(e0));
        chk("C_rx_data", 32'(rx_data), 32'(m0));
        chk("C_underrun_hold", 32'(tx_underrun), 32'(munder));
        load(8'h11);
        chk("C_underrun_clr", 32'(tx_underrun), 32'(munder));
        load(8'h99);
        chk("C_tx_ready_full", 32'(tx_ready), 32'(!mfull));

        // Back-to-back bytes, mode 1; lsbfe pin flipped mid-frame must be ignored
        set_mode(1'b0, 1'b1, 1'b0);
        frame_begin();
        lsbfe = 1'b1;
        e0 = m_take();
        m0 = 8'($urandom);
        m1 = 8'($urandom);
        fork
            xfer(m0, 8, mi0);
            begin #(4*H); load(8'h22); end
        join
        e1 = m_take();
        xfer(m1, 8, mi1);
        void'(m_take());
        frame_end();
        lsbfe = 1'b0;
        rx_last = m1;
        chk("D_miso0", 32'(mi0), 32'(e0));
        chk("D_miso1", 32'(mi1), 32'(e1));
        chk("D_rx_pulses", 32'(rxv_n), 32'd2);
        chk("D_rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'(m0));
        chk("D_rx1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'(m1));

        // ss rises after 5 sample edges, mode 2
        set_mode(1'b1, 1'b0, 1'b0);
        frame_begin();
        void'(m_take());
        xfer(8'($urandom), 5, mi0);
        frame_end();
        chk("E_frame_err", 32'(ferr_n), 32'd1);
        chk("E_rx_pulses", 32'(rxv_n), 32'd0);
        chk("E_rx_data", 32'(rx_data), 32'(rx_last));

        // Reset mid-byte
        set_mode(1'b0, 1'b0, 1'b0);
        load(8'($urandom));
        frame_begin();
        void'(m_take());
        xfer(8'($urandom), 4, mi0);
        PRESETn = 1'b0;
        mfull = 1'b0; munder = 1'b0; rx_last = 8'h00;
        #20;
        chk("F_miso", 32'(miso), 32'd0);
        chk("F_rx_data", 32'(rx_data), 32'd0);
        chk("F_tx_ready", 32'(tx_ready), 32'd1);
        chk("F_underrun", 32'(tx_underrun), 32'd0);
        chk("F_rx_valid", 32'(rx_valid), 32'd0);
        PRESETn = 1'b1;
        #20;
        xfer(8'($urandom), 3, mi0);
        ss = 1'b1;
        #(3*H);
        chk("F_no_rx", 32'(rxv_n), 32'd0);
        chk("F_no_ferr", 32'(ferr_n), 32'd0);

        // Randomized frames
        for (int f = 0; f < 5; f++) begin
            set_mode(1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) load(8'($urandom));
            nb = $urandom_range(1, 2);
            for (int j = 0; j < 2; j++) begin
                mo[j]  = 8'($urandom);
                ld[j]  = 1'($urandom);
                ldd[j] = 8'($urandom);
            end
            frame_begin();
            ex[0] = m_take();
            for (int j = 0; j < nb; j++) begin
                fork
                    xfer(mo[j], 8, mi[j]);
                    begin #(4*H); if (ld[j]) load(ldd[j]); end
                join
                ex[j+1] = m_take();
            end
            frame_end();
            chk("R_rx_pulses", 32'(rxv_n), 32'(nb));
            for (int j = 0; j < nb; j++) begin
                chk("R_miso", 32'(mi[j]), 32'(ex[j]));
                chk("R_rx", 32'(rx_q.size() > j ? rx_q[j] : 8'hxx), 32'(mo[j]));
            end
            chk("R_underrun", 32'(tx_underrun), 32'(munder));
            chk("R_tx_ready", 32'(tx_ready), 32'(!mfull));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
